// File: rtl/register_file.sv
// rtl/register_file.sv - 16-entry register file, r0 hardwired to zero, two combinational read ports
`timescale 1ns/1ps

module register_file #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [3:0]           waddr,
    input  logic [BUS_WIDTH-1:0] wdata,
    input  logic [3:0]           raddr_a,
    input  logic [3:0]           raddr_b,
    output logic [BUS_WIDTH-1:0] rdata_a,
    output logic [BUS_WIDTH-1:0] rdata_b,
    output logic [7:0]           wr_count
);

    // r0 has no storage; index 0 falls through to the zero default on reads
    logic [15:1][BUS_WIDTH-1:0] regs;
    logic                       wr_commit;

    assign wr_commit = we && (waddr != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '0;
            wr_count <= 8'd0;
        end else if (wr_commit) begin
            for (int i = 1; i < 16; i++) begin
                if (waddr == 4'(i)) begin
                    regs[i] <= wdata;
                end
            end
            wr_count <= wr_count + 8'd1;
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 1; i < 16; i++) begin
            if (raddr_a == 4'(i)) begin
                rdata_a = regs[i];
            end
            if (raddr_b == 4'(i)) begin
                rdata_b = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
`timescale 1ns/1ps

module tb_register_file;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] raddr_a;
    logic [3:0] raddr_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic [7:0] wr_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  model_regs [16];
    logic [7:0]  model_cnt;
    string       tag_q [$];
    int unsigned exp_q [$];
    logic [7:0]  last_d;

    register_file #(.BUS_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_cnt = 8'd0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        if (a != 4'd0) begin
            model_regs[a] = d;
            model_cnt     = model_cnt + 8'd1;
        end
    endtask

    // Drive both read addresses, queue expectations, then compare after dly
    task automatic read_ports(input string tag, input logic [3:0] a, input logic [3:0] b, input realtime dly);
        raddr_a = a;
        raddr_b = b;
        tag_q.push_back({tag, "_a"});   exp_q.push_back(int'(model_regs[a]));
        tag_q.push_back({tag, "_b"});   exp_q.push_back(int'(model_regs[b]));
        tag_q.push_back({tag, "_cnt"}); exp_q.push_back(int'(model_cnt));
        #dly;
        check(tag_q.pop_front(), int'(rdata_a), exp_q.pop_front());
        check(tag_q.pop_front(), int'(rdata_b), exp_q.pop_front());
        check(tag_q.pop_front(), int'(wr_count), exp_q.pop_front());
    endtask

    // Called just after a negedge; returns just after the following negedge
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        model_write(a, d);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = 4'd0;
        wdata   = 8'h00;
        raddr_a = 4'd0;
        raddr_b = 4'd0;
        model_clear();

        #2;
        read_ports("in_reset", 4'd3, 4'd15, 1.0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            read_ports("reset_read", 4'(i), 4'(15 - i), 0.5);
        end

        do_write(4'd3, 8'hA5);
        read_ports("write_r3", 4'd3, 4'd3, 1.0);

        do_write(4'd0, 8'hFF);
        read_ports("write_r0", 4'd0, 4'd3, 1.0);

        // No bypass: old value before the edge, new value after
        do_write(4'd5, 8'h11);
        we    = 1'b1;
        waddr = 4'd5;
        wdata = 8'h22;
        read_ports("pre_edge_r5", 4'd3, 4'd5, 1.0);
        @(posedge clk);
        model_write(4'd5, 8'h22);
        #1;
        read_ports("post_edge_r5", 4'd5, 4'd5, 1.0);
        @(negedge clk);
        we = 1'b0;

        apply_reset();
        last_d = 8'h00;
        for (int i = 0; i < 256; i++) begin
            last_d = 8'($urandom_range(0, 255));
            do_write(4'd7, last_d);
            if (i == 254) read_ports("wrap_255", 4'd7, 4'd0, 1.0);
        end
        read_ports("wrap_0", 4'd7, 4'd7, 1.0);
        check("wrap_last_r7", int'(rdata_a), int'(last_d));
        check("wrap_cnt_zero", int'(wr_count), 0);

        for (int i = 1; i < 16; i++) begin
            do_write(4'(i), 8'(i));
        end
        read_ports("filled", 4'd1, 4'd15, 1.0);

        // Reset pulse between edges: all reads must clear before the next posedge
        #1;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            read_ports("async_clear", 4'(2 * i), 4'(2 * i + 1), 0.2);
        end
        we    = 1'b1;
        waddr = 4'd9;
        wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b0;
        read_ports("write_in_reset", 4'd9, 4'd1, 1.0);

        @(negedge clk);
        do_write(4'd9, 8'h3C);
        read_ports("after_reset_write", 4'd9, 4'd9, 1.0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
